// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / HOST_ACC / HOST_RSP)
//   SIZE_*/RW_* : RAM size and direction encodings
//   is_misaligned(): a word access needs a 4-byte aligned address
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOST_ACC = 2'd1,
    HOST_RSP = 2'd2
  } arb_state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  function automatic logic is_misaligned(input logic size, input logic [1:0] lsb);
    return (size == SIZE_WORD) && (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_ctr.sv
// host_wait_ctr: saturating count of contended cycles for a pending host request.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one contended cycle (holds at MAX_VAL)
//   clr      : return to zero (wins over inc)
//   at_max   : count has reached MAX_VAL
module host_wait_ctr #(
  parameter int unsigned MAX_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_VAL);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 4'd1;
  end

  assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the ram256x8 data port between the pipeline MEM
// stage (priority) and a host loader/readback port.
//   clk, R          : clock, asynchronous active-high reset
//   pipe_*          : MEM stage request; pipe_stall holds the pipeline while
//                     the host owns the port; pipe_rdata = ram_DO always
//   host_*          : level request held until host_ack; host_ack/host_err
//                     pulse one cycle; host_rdata registered read data
//   ram_*           : RAM port (E, RW, Size, Addd, DI out; DO in)
// Optional build macro MEM_ARB_STATS_EN adds stat_host_grants and
// stat_stall_cycles (16-bit saturating counters).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        R,
  input  logic        pipe_req,
  input  logic        pipe_rw,
  input  logic        pipe_size,
  input  logic [7:0]  pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        pipe_stall,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic        host_size,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [31:0] host_rdata,
  output logic        ram_E,
  output logic        ram_RW,
  output logic        ram_Size,
  output logic [7:0]  ram_Addd,
  output logic [31:0] ram_DI,
  input  logic [31:0] ram_DO
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_host_grants,
  output logic [15:0] stat_stall_cycles
`endif
);

  arb_state_e  state, state_next;
  logic        cap_rw, cap_size, cap_err;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic        wait_at_max, grant, wait_inc, wait_clr;

  host_wait_ctr #(.MAX_VAL(HOST_MAX_WAIT)) u_wait_ctr (
    .clk    (clk),
    .rst    (R),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .at_max (wait_at_max)
  );

  assign grant    = (state == IDLE) && host_req && (!pipe_req || wait_at_max);
  assign wait_inc = (state == IDLE) && host_req && pipe_req && !grant;
  assign wait_clr = (state == IDLE) && (grant || !host_req);

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_next;
  end

  always_comb begin
    state_next = state;
    pipe_stall = 1'b0;
    host_ack   = 1'b0;
    host_err   = 1'b0;
    ram_E      = pipe_req;
    ram_RW     = pipe_rw;
    ram_Size   = pipe_size;
    ram_Addd   = pipe_addr;
    ram_DI     = pipe_wdata;
    unique case (state)
      IDLE: begin
        // A misaligned word request skips the RAM cycle entirely.
        if (grant)
          state_next = is_misaligned(host_size, host_addr[1:0]) ? HOST_RSP : HOST_ACC;
      end
      HOST_ACC: begin
        ram_E      = 1'b1;
        ram_RW     = cap_rw;
        ram_Size   = cap_size;
        ram_Addd   = cap_addr;
        ram_DI     = cap_wdata;
        pipe_stall = pipe_req;
        state_next = HOST_RSP;
      end
      HOST_RSP: begin
        host_ack   = 1'b1;
        host_err   = cap_err;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      cap_rw     <= 1'b0;
      cap_size   <= 1'b0;
      cap_err    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      host_rdata <= '0;
    end else begin
      if (grant) begin
        cap_rw    <= host_rw;
        cap_size  <= host_size;
        cap_addr  <= host_addr;
        cap_wdata <= host_wdata;
        cap_err   <= is_misaligned(host_size, host_addr[1:0]);
      end
      if (state == HOST_ACC && cap_rw == RW_READ)
        host_rdata <= ram_DO;
    end
  end

  assign pipe_rdata = ram_DO;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stat_host_grants  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (state_next == HOST_ACC && state != HOST_ACC && stat_host_grants != '1)
        stat_host_grants <= stat_host_grants + 16'd1;
      if (pipe_stall && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        R;
  logic        pipe_req, pipe_rw, pipe_size;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        host_req, host_rw, host_size;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack, host_err;
  logic [31:0] host_rdata;
  logic        ram_E, ram_RW, ram_Size;
  logic [7:0]  ram_Addd;
  logic [31:0] ram_DI, ram_DO;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_host_grants, stat_stall_cycles;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.HOST_MAX_WAIT(4)) dut (
    .clk(clk), .R(R),
    .pipe_req(pipe_req), .pipe_rw(pipe_rw), .pipe_size(pipe_size),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata),
    .pipe_stall(pipe_stall),
    .host_req(host_req), .host_rw(host_rw), .host_size(host_size),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .ram_E(ram_E), .ram_RW(ram_RW), .ram_Size(ram_Size), .ram_Addd(ram_Addd),
    .ram_DI(ram_DI), .ram_DO(ram_DO)
`ifdef MEM_ARB_STATS_EN
    , .stat_host_grants(stat_host_grants), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // RAM model: little-endian words, byte data in [7:0], async read.
  logic [7:0] mem [256];
  logic [7:0] a1, a2, a3;
  assign a1 = ram_Addd + 8'd1;
  assign a2 = ram_Addd + 8'd2;
  assign a3 = ram_Addd + 8'd3;
  assign ram_DO = ram_Size ? {mem[a3], mem[a2], mem[a1], mem[ram_Addd]}
                           : {24'h0, mem[ram_Addd]};

  always @(posedge clk) begin
    if (ram_E && ram_RW) begin
      mem[ram_Addd] <= ram_DI[7:0];
      if (ram_Size) begin
        mem[a1] <= ram_DI[15:8];
        mem[a2] <= ram_DI[23:16];
        mem[a3] <= ram_DI[31:24];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b1;
    pipe_req = 0; pipe_rw = 0; pipe_size = 0; pipe_addr = 0; pipe_wdata = 0;
    host_req = 0; host_rw = 0; host_size = 0; host_addr = 0; host_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();
    checks++; if (host_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", host_ack); end
    checks++; if (host_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", host_err); end
    checks++; if (host_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", host_rdata); end
    checks++; if (pipe_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", pipe_stall); end
    pipe_req = 1; pipe_rw = 1; pipe_size = 1; pipe_addr = 8'h44; pipe_wdata = 32'hCAFE0001;
    #1;
    checks++; if ({ram_E, ram_RW, ram_Size, ram_Addd, ram_DI} !== {3'b111, 8'h44, 32'hCAFE0001}) begin
      fails++; $display("FAIL reset_passthru: got %b%b%b %h %h expected 111 44 cafe0001", ram_E, ram_RW, ram_Size, ram_Addd, ram_DI);
    end
    pipe_req = 0; pipe_rw = 0; pipe_size = 0; pipe_addr = 0; pipe_wdata = 0;
    R = 1'b0;
    tick();
  endtask

  task automatic test_host_write_read();
    host_req = 1; host_rw = 1; host_size = 1; host_addr = 8'd52; host_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (ram_E !== 1'b0) begin fails++; $display("FAIL wr_c0_ramE: got %b expected 0", ram_E); end
    tick();
    checks++; if ({ram_E, ram_RW, ram_Size, ram_Addd} !== {3'b111, 8'd52}) begin
      fails++; $display("FAIL wr_c1_ram: got %b%b%b %0d expected 111 52", ram_E, ram_RW, ram_Size, ram_Addd);
    end
    checks++; if (ram_DI !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_c1_DI: got %h expected deadbeef", ram_DI); end
    checks++; if (host_ack !== 1'b0) begin fails++; $display("FAIL wr_c1_ack: got %b expected 0", host_ack); end
    tick();
    checks++; if ({host_ack, host_err} !== 2'b10) begin fails++; $display("FAIL wr_c2_ack_err: got %b%b expected 10", host_ack, host_err); end
    host_req = 0;
    tick();
    checks++; if (host_ack !== 1'b0) begin fails++; $display("FAIL wr_c3_ack: got %b expected 0", host_ack); end
    host_req = 1; host_rw = 0; host_size = 1; host_addr = 8'd52;
    tick(); tick();
    checks++; if (host_ack !== 1'b1) begin fails++; $display("FAIL rd52_ack: got %b expected 1", host_ack); end
    checks++; if (host_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd52_data: got %h expected deadbeef", host_rdata); end
    host_req = 0;
    tick();
  endtask

  task automatic test_host_byte_read();
    int stalls = 0;
    mem[56] = 8'h3C;
    host_req = 1; host_rw = 0; host_size = 0; host_addr = 8'd56;
    #1; if (pipe_stall) stalls++;
    tick(); if (pipe_stall) stalls++;
    tick(); if (pipe_stall) stalls++;
    checks++; if ({host_ack, host_err} !== 2'b10) begin fails++; $display("FAIL brd_ack: got %b%b expected 10", host_ack, host_err); end
    checks++; if (host_rdata !== 32'h0000003C) begin fails++; $display("FAIL brd_data: got %h expected 0000003c", host_rdata); end
    checks++; if (stalls !== 0) begin fails++; $display("FAIL brd_stall: got %0d stall cycles expected 0", stalls); end
    host_req = 0;
    tick();
  endtask

  task automatic test_contended();
    int stalls = 0;
    int ack_cyc = -1;
    mem[10] = 8'h5A; mem[57] = 8'hA5;
    pipe_req = 1; pipe_rw = 0; pipe_size = 0; pipe_addr = 8'd10;
    host_req = 1; host_rw = 0; host_size = 0; host_addr = 8'd57;
    #1;
    checks++; if (pipe_rdata !== 32'h0000005A) begin fails++; $display("FAIL cont_pipe_rdata: got %h expected 0000005a", pipe_rdata); end
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick();
      if (pipe_stall) stalls++;
      if (host_ack && ack_cyc < 0) ack_cyc = c;
      if (c == 4) begin
        checks++; if (ram_Addd !== 8'd10) begin fails++; $display("FAIL cont_c4_addr: got %0d expected 10", ram_Addd); end
      end
      if (c == 5) begin
        checks++; if ({pipe_stall, ram_E, ram_Addd} !== {2'b11, 8'd57}) begin
          fails++; $display("FAIL cont_c5_acc: got stall=%b E=%b addr=%0d expected 1 1 57", pipe_stall, ram_E, ram_Addd);
        end
      end
    end
    checks++; if (stalls !== 1) begin fails++; $display("FAIL cont_stalls: got %0d expected 1", stalls); end
    checks++; if (ack_cyc !== 6) begin fails++; $display("FAIL cont_ack_cycle: got %0d expected 6", ack_cyc); end
    checks++; if (host_rdata !== 32'h000000A5) begin fails++; $display("FAIL cont_data: got %h expected 000000a5", host_rdata); end
    host_req = 0; pipe_req = 0;
    tick();
  endtask

  task automatic test_misaligned();
    int stalls = 0;
    int ram_e_seen = 0;
    host_req = 1; host_rw = 0; host_size = 1; host_addr = 8'd53;
    #1; if (pipe_stall) stalls++; if (ram_E) ram_e_seen++;
    tick(); if (pipe_stall) stalls++; if (ram_E) ram_e_seen++;
    checks++; if ({host_ack, host_err} !== 2'b11) begin fails++; $display("FAIL mis_ack_err: got %b%b expected 11", host_ack, host_err); end
    host_req = 0;
    tick(); if (pipe_stall) stalls++; if (ram_E) ram_e_seen++;
    checks++; if ({host_ack, host_err} !== 2'b00) begin fails++; $display("FAIL mis_after: got %b%b expected 00", host_ack, host_err); end
    checks++; if (stalls !== 0) begin fails++; $display("FAIL mis_stall: got %0d expected 0", stalls); end
    checks++; if (ram_e_seen !== 0) begin fails++; $display("FAIL mis_ramE: got %0d expected 0", ram_e_seen); end
  endtask

  task automatic test_simultaneous();
    pipe_req = 1; pipe_rw = 1; pipe_size = 0; pipe_addr = 8'd58; pipe_wdata = 32'h00000077;
    host_req = 1; host_rw = 0; host_size = 0; host_addr = 8'd56;
    #1;
    checks++; if ({pipe_stall, ram_E, ram_RW, ram_Addd} !== {3'b011, 8'd58}) begin
      fails++; $display("FAIL sim_c0: got stall=%b E=%b RW=%b addr=%0d expected 0 1 1 58", pipe_stall, ram_E, ram_RW, ram_Addd);
    end
    tick();
    checks++; if (mem[58] !== 8'h77) begin fails++; $display("FAIL sim_write: got %h expected 77", mem[58]); end
    checks++; if ({host_ack, pipe_stall, ram_Addd} !== {2'b00, 8'd58}) begin
      fails++; $display("FAIL sim_nogrant: got ack=%b stall=%b addr=%0d expected 0 0 58", host_ack, pipe_stall, ram_Addd);
    end
    checks++; if (dut.u_wait_ctr.cnt !== 4'd1) begin fails++; $display("FAIL sim_wait_cnt: got %0d expected 1", dut.u_wait_ctr.cnt); end
    host_req = 0; pipe_req = 0;
    tick();
    checks++; if (dut.u_wait_ctr.cnt !== 4'd0) begin fails++; $display("FAIL sim_wait_clr: got %0d expected 0", dut.u_wait_ctr.cnt); end
  endtask

  task automatic test_back_to_back();
    host_req = 1; host_rw = 0; host_size = 1; host_addr = 8'd52;
    tick(); tick();
    checks++; if (host_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack1: got %b expected 1", host_ack); end
    tick();
    checks++; if ({host_ack, ram_E} !== 2'b00) begin fails++; $display("FAIL b2b_idle: got ack=%b E=%b expected 0 0", host_ack, ram_E); end
    tick();
    checks++; if ({ram_E, ram_Addd} !== {1'b1, 8'd52}) begin fails++; $display("FAIL b2b_regrant: got E=%b addr=%0d expected 1 52", ram_E, ram_Addd); end
    host_req = 0;
    tick();
    checks++; if ({host_ack, host_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      fails++; $display("FAIL b2b_ack2: got ack=%b data=%h expected 1 deadbeef", host_ack, host_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    host_req = 1; host_rw = 0; host_size = 0; host_addr = 8'd56; pipe_req = 0;
    tick();
    pipe_req = 1; pipe_addr = 8'd20; pipe_rw = 0;
    #1;
    checks++; if ({pipe_stall, ram_Addd} !== {1'b1, 8'd56}) begin fails++; $display("FAIL rmid_acc: got stall=%b addr=%0d expected 1 56", pipe_stall, ram_Addd); end
    R = 1'b1;
    #1;
    checks++; if ({pipe_stall, host_ack, host_rdata} !== 34'h0) begin
      fails++; $display("FAIL rmid_async: got stall=%b ack=%b data=%h expected 0 0 0", pipe_stall, host_ack, host_rdata);
    end
    checks++; if (ram_Addd !== 8'd20) begin fails++; $display("FAIL rmid_passthru: got %0d expected 20", ram_Addd); end
    #1;
    R = 1'b0; host_req = 0; pipe_req = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (host_ack) acks++;
    end
    checks++; if (acks !== 0) begin fails++; $display("FAIL rmid_noack: got %0d acks expected 0", acks); end
  endtask

  initial begin
    test_reset();
    test_host_write_read();
    test_host_byte_read();
    test_contended();
    test_misaligned();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
